// File: rtl/conv_kxk_pipe_mac.sv
// Pipelined KxK convolution MAC: per-tap multiply, registered binary adder tree, clamp/wrap to OUT_W.
// Latency 1+$clog2(TAPS); the whole pipe freezes while a result waits, so in_ready = ~out_valid | out_ready.
module conv_kxk_pipe_mac #(
    parameter int DATA_W = 6,
    parameter int COEF_W = 6,
    parameter int TAPS   = 9,
    parameter int OUT_W  = 18,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    k_we,
    input  logic [$clog2(TAPS)-1:0] k_idx,
    input  logic [COEF_W-1:0]       k_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAPS*DATA_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data
);
    localparam int IDX_W = $clog2(TAPS);
    localparam int LV    = $clog2(TAPS);
    localparam int P     = DATA_W + COEF_W;
    localparam int F     = P + LV;

    // Node count of tree level l (level 0 holds the products).
    function automatic int lvl_cnt(input int l);
        int n;
        n = TAPS;
        for (int j = 0; j < l; j++) n = (n + 1) / 2;
        return n;
    endfunction

    // All levels live in one flat node array; this gives the first index of level l.
    function automatic int lvl_base(input int l);
        int b;
        b = 0;
        for (int j = 0; j < l; j++) b += lvl_cnt(j);
        return b;
    endfunction

    localparam int NODES = lvl_base(LV + 1);

    logic [F-1:0]      node_d [NODES];
    logic [F-1:0]      node_q [NODES];
    logic [COEF_W-1:0] coef_d [TAPS];
    logic [COEF_W-1:0] coef_q [TAPS];
    logic [LV:0]       vld_d;
    logic [LV:0]       vld_q;
    logic              en;
    logic              k_ok;
    logic [F-1:0]      sum;

    assign en        = ~vld_q[LV] | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[LV];
    assign vld_d     = {vld_q[LV-1:0], in_valid};
    assign k_ok      = ({1'b0, k_idx} < (IDX_W + 1)'(TAPS));

    // Products sample coef_q, so a write landing on the accept edge only affects later windows.
    always_comb begin
        coef_d = coef_q;
        if (k_we && k_ok) coef_d[k_idx] = k_data;
    end

    for (genvar t = 0; t < TAPS; t++) begin : g_prod
        logic [F-1:0] px;
        logic [F-1:0] cf;
        assign px = (SIGNED != 0)
                  ? {{(F-DATA_W){in_data[t*DATA_W+DATA_W-1]}}, in_data[t*DATA_W +: DATA_W]}
                  : F'(in_data[t*DATA_W +: DATA_W]);
        assign cf = (SIGNED != 0)
                  ? {{(F-COEF_W){coef_q[t][COEF_W-1]}}, coef_q[t]}
                  : F'(coef_q[t]);
        assign node_d[t] = px * cf;
    end

    // An unpaired last node is forwarded through a register so every path has equal depth.
    for (genvar l = 1; l <= LV; l++) begin : g_lvl
        for (genvar i = 0; i < lvl_cnt(l); i++) begin : g_node
            localparam int A = lvl_base(l - 1) + 2 * i;
            localparam int D = lvl_base(l) + i;
            if (2 * i + 1 < lvl_cnt(l - 1)) begin : g_add
                assign node_d[D] = node_q[A] + node_q[A+1];
            end else begin : g_pass
                assign node_d[D] = node_q[A];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_q <= '{default: '0};
            coef_q <= '{default: '0};
            vld_q  <= '0;
        end else begin
            coef_q <= coef_d;
            if (en) begin
                node_q <= node_d;
                vld_q  <= vld_d;
            end
        end
    end

    assign sum = node_q[NODES-1];

    if (F <= OUT_W) begin : g_ext
        assign out_data = (SIGNED != 0) ? OUT_W'($signed(sum)) : OUT_W'(sum);
    end else begin : g_clip
        logic             ovf;
        logic [OUT_W-1:0] lim;
        always_comb begin
            if (SIGNED != 0) begin
                ovf = !((&sum[F-1:OUT_W-1]) || !(|sum[F-1:OUT_W-1]));
                lim = sum[F-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                ovf = |sum[F-1:OUT_W];
                lim = '1;
            end
        end
        assign out_data = ((SAT != 0) && ovf) ? lim : sum[OUT_W-1:0];
    end

endmodule

// File: tb/tb_conv_kxk_pipe_mac.sv
// Directed bench for conv_kxk_pipe_mac: four parameterisations share one stimulus stream.
module tb_conv_kxk_pipe_mac;
    localparam int TAPS = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        k_we;
    logic [3:0]  k_idx;
    logic [5:0]  k_data;
    logic        in_valid;
    logic [53:0] in_data;
    logic        out_ready;

    logic        rdy_u, rdy_s, rdy_c, rdy_w;
    logic        vld_u, vld_s, vld_c, vld_w;
    logic [17:0] dat_u, dat_s;
    logic [11:0] dat_c, dat_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv_kxk_pipe_mac u_dut (
        .clk(clk), .rst(rst), .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
        .in_valid(in_valid), .in_ready(rdy_u), .in_data(in_data),
        .out_valid(vld_u), .out_ready(out_ready), .out_data(dat_u));

    conv_kxk_pipe_mac #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
        .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
        .out_valid(vld_s), .out_ready(out_ready), .out_data(dat_s));

    conv_kxk_pipe_mac #(.OUT_W(12), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
        .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
        .out_valid(vld_c), .out_ready(out_ready), .out_data(dat_c));

    conv_kxk_pipe_mac #(.OUT_W(12), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
        .in_valid(in_valid), .in_ready(rdy_w), .in_data(in_data),
        .out_valid(vld_w), .out_ready(out_ready), .out_data(dat_w));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_kernel(input logic [5:0] v);
        for (int t = 0; t < TAPS; t++) begin
            k_we   = 1'b1;
            k_idx  = 4'(t);
            k_data = v;
            tick();
        end
        k_we = 1'b0;
    endtask

    task automatic set_pix(input logic [5:0] p);
        in_data = {TAPS{p}};
    endtask

    // One beat, then wait (bounded) for the result; lat counts cycles from the beat.
    task automatic run_one(output int lat);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!vld_u && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, got, first, last, beat, exp_n, hold, seen, n, stale;

        rst = 1'b1; k_we = 1'b0; k_idx = '0; k_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        check("rst_vld_u", 32'(vld_u), 0);
        check("rst_vld_all", 32'({vld_s, vld_c, vld_w}), 0);
        check("rst_dat_u", 32'(dat_u), 0);
        check("rst_rdy_all", 32'({rdy_u, rdy_s, rdy_c, rdy_w}), 32'hF);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic: all ones -> 9 after five cycles
        load_kernel(6'd1);
        set_pix(6'd1);
        run_one(lat);
        check("t1_latency", 32'(lat), 5);
        check("t1_dat_u", 32'(dat_u), 9);
        check("t1_dat_s", 32'(dat_s), 9);
        tick();
        check("t1_vld_drop", 32'(vld_u), 0);

        // Max values, clamp and wrap variants
        load_kernel(6'd63);
        set_pix(6'd63);
        run_one(lat);
        check("t2_max_u", 32'(dat_u), 35721);
        check("t2_sat", 32'(dat_c), 4095);
        check("t2_wrap", 32'(dat_w), 2953);
        check("t2_sgn_m1", 32'(dat_s), 9);
        tick();

        // Streaming 20 beats, pixel b -> 9*63*b
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            in_valid = (c < 20);
            set_pix(6'(c + 1));
            tick();
            if (vld_u) begin
                check("t2_stream", 32'(dat_u), 32'(567 * (got + 1)));
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        in_valid = 1'b0;
        check("t2_stream_cnt", 32'(got), 20);
        check("t2_stream_gap", 32'(last - first), 19);

        // Signed operands
        load_kernel(6'h20);
        set_pix(6'h20);
        run_one(lat);
        check("t3_sgn_pos", 32'(dat_s), 9216);
        check("t3_uns_32", 32'(dat_u), 9216);
        tick();
        load_kernel(6'h1F);
        run_one(lat);
        check("t3_sgn_neg", 32'(dat_s), 253216);
        check("t3_uns_31", 32'(dat_u), 8928);
        tick();

        // Backpressure: hold out_ready low for 3 cycles when the first result appears
        load_kernel(6'd1);
        beat = 1; exp_n = 1; hold = 0; seen = 0;
        for (int c = 0; c < 60 && exp_n <= 6; c++) begin
            if (!seen && vld_u) begin
                seen = 1;
                hold = 3;
            end
            out_ready = (hold == 0);
            in_valid  = (beat <= 6);
            set_pix(6'(beat));
            #1;
            if (hold > 0) begin
                check("t4_rdy_low", 32'(rdy_u), 0);
                check("t4_hold_dat", 32'(dat_u), 32'(9 * exp_n));
            end
            if (vld_u && out_ready) begin
                check("t4_order", 32'(dat_u), 32'(9 * exp_n));
                exp_n++;
            end
            if (in_valid && rdy_u) beat++;
            tick();
            if (hold > 0) hold--;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("t4_results", 32'(exp_n), 7);
        check("t4_accepted", 32'(beat), 7);
        check("t4_stall_seen", 32'(seen), 1);
        tick();
        check("t4_drained", 32'(vld_u), 0);

        // Coefficient write coinciding with an accept
        k_we = 1'b1; k_idx = 4'd4; k_data = 6'd0;
        tick();
        k_idx = 4'd13; k_data = 6'd63;
        tick();
        set_pix(6'd1);
        in_valid = 1'b1; k_idx = 4'd4; k_data = 6'd5;
        tick();
        k_we = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (vld_u) begin
                check(n == 0 ? "t5_old_coef" : "t5_new_coef", 32'(dat_u), n == 0 ? 8 : 13);
                n++;
            end
            tick();
        end
        check("t5_count", 32'(n), 2);

        // Reset mid-stream
        load_kernel(6'd63);
        set_pix(6'd63);
        in_valid = 1'b1;
        repeat (7) tick();
        check("t6_pre_vld", 32'(vld_u), 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_vld", 32'({vld_u, vld_c}), 0);
        check("t6_rst_dat", 32'(dat_u), 0);
        check("t6_rst_rdy", 32'(rdy_u), 1);
        tick(); tick();
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vld_u) stale++;
        end
        check("t6_no_stale", 32'(stale), 0);
        run_one(lat);
        check("t6_post_lat", 32'(lat), 5);
        check("t6_kernel_clr", 32'(dat_u), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
